fifo_rd_ctrl: RTL

- Read-side controller for the 128-bit synchronous FIFO (1024-deep).
- Issues the FIFO read enable and captures the read data in the same cycle, because the FIFO read data is only driven while read enable is high.
- Holds captured data in a 2-entry skid buffer and presents it downstream as a valid/ready stream, framed into fixed-length bursts with a last marker.
- Sits between the FIFO read port and the downstream consumer; it is the consuming counterpart of the FIFO writer.

---
 rtl/fifo_rd_pkg.sv | 14 +
 rtl/fifo_rd_skid.sv | 66 ++++++
 rtl/fifo_rd_ctrl.sv | 102 ++++++++++
 3 files changed

// File: rtl/fifo_rd_pkg.sv
// fifo_rd_pkg: shared types and constants for the FIFO read-side controller.
// Holds the controller state encoding, default data width and beat index width.
package fifo_rd_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  localparam int DATA_WIDTH_DEF = 128;
  localparam int BEAT_IDX_W     = 8;

endpackage

// File: rtl/fifo_rd_skid.sv
// fifo_rd_skid: 2-entry in-order skid buffer between FIFO read port and stream.
// Ports: clk, reset_n (sync, low), push/din, pop, dout (head), valid, occ.
module fifo_rd_skid
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  valid,
  output logic [1:0]            occ
);

  logic [DATA_WIDTH-1:0] head;
  logic [DATA_WIDTH-1:0] tail;

  // head always holds the oldest beat; tail is only used when two are held
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      head <= '0;
      tail <= '0;
      occ  <= 2'd0;
    end else begin
      case (occ)
        2'd0: begin
          if (push) begin
            head <= din;
            occ  <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            head <= din;
          end else if (push) begin
            tail <= din;
            occ  <= 2'd2;
          end else if (pop) begin
            occ  <= 2'd0;
          end
        end
        2'd2: begin
          // a push while full only ever arrives together with a pop
          if (pop) begin
            head <= tail;
            if (push) begin
              tail <= din;
            end else begin
              occ  <= 2'd1;
            end
          end
        end
        default: begin
          occ <= 2'd0;
        end
      endcase
    end
  end

  assign dout  = head;
  assign valid = (occ != 2'd0);

endmodule

// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: reads the 128-bit FIFO and streams its words as fixed bursts.
// Ports: FIFO side (empty, rddata, rden), stream (valid/ready/data/last), status.
module fifo_rd_ctrl
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int BURST_LEN  = 16,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_enable,
  input  logic                  i_fifo_empty,
  input  logic [DATA_WIDTH-1:0] i_fifo_rddata,
  output logic                  o_fifo_rden,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  o_busy,
  output logic [BEAT_IDX_W-1:0] o_beat_idx,
  output logic [CNT_W-1:0]      o_burst_cnt
);

  localparam logic [BEAT_IDX_W-1:0] LAST_IDX =
    BEAT_IDX_W'(BURST_LEN - 1);

  state_t     state;
  logic [1:0] occ;
  logic       pop;
  logic       drain_last;

  assign pop = m_valid & m_ready;

  // read data is only driven while rden is high, so the skid
  // captures it in the same cycle; a pop frees a slot for it
  assign o_fifo_rden = reset_n
                     & (state == STREAM)
                     & !i_fifo_empty
                     & ((occ != 2'd2) | pop);

  // in DRAIN nothing more is read, so the single remaining
  // beat closes whatever partial burst is open
  assign drain_last = (state == DRAIN) & (occ == 2'd1);

  assign m_last = m_valid
                & ((o_beat_idx == LAST_IDX) | drain_last);

  assign o_busy = (state != IDLE);

  fifo_rd_skid #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (o_fifo_rden),
    .din     (i_fifo_rddata),
    .pop     (pop),
    .dout    (m_data),
    .valid   (m_valid),
    .occ     (occ)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      o_beat_idx  <= '0;
      o_burst_cnt <= '0;
    end else begin
      if (pop) begin
        if (m_last) begin
          o_beat_idx  <= '0;
          o_burst_cnt <= o_burst_cnt + CNT_W'(1);
        end else begin
          o_beat_idx  <= o_beat_idx + BEAT_IDX_W'(1);
        end
      end

      case (state)
        IDLE: begin
          if (i_enable && !i_fifo_empty) begin
            state <= STREAM;
          end
        end
        STREAM: begin
          if (!i_enable) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if ((occ == 2'd0) || ((occ == 2'd1) && pop)) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
